rpm_band_moore: RTL and testbench

- Upstream stage of the gear/mode Mealy FSM.
- Measures engine speed by counting tachometer pulses over a fixed window of clock cycles.
- Classifies the count into four revolution bands with hysteresis, using a Moore FSM.
- Drives the 2-bit band code C consumed by the gear/mode Mealy FSM, which also receives the A on/off signal shared by both blocks.

---
 rtl/rpm_band_moore.sv | 142 ++++++++++++++
 tb/tb_rpm_band_moore.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rpm_band_moore.sv
// rpm_band_moore: tachometer edge counter over a fixed window, feeding a
// four-band Moore classifier with downward hysteresis.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   A            engine on (1) / off (0), synchronous to clk
//   pulse        raw tachometer pulse, asynchronous to clk
//   C            revolution band 00 idle / 01 low / 10 mid / 11 high (registered)
//   rpm_count    edge count of the last completed window
//   sample_valid 1-cycle strobe, rpm_count updated
//   band_change  1-cycle strobe, C changed this cycle
module rpm_band_moore #(
  parameter int unsigned WINDOW_CYCLES = 1000,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned TH1           = 10,
  parameter int unsigned TH2           = 25,
  parameter int unsigned TH3           = 40,
  parameter int unsigned HYST          = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             A,
  input  logic             pulse,
  output logic [1:0]       C,
  output logic [CNT_W-1:0] rpm_count,
  output logic             sample_valid,
  output logic             band_change
);

  localparam int unsigned WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TH1_UP   = CNT_W'(TH1);
  localparam logic [CNT_W-1:0] TH2_UP   = CNT_W'(TH2);
  localparam logic [CNT_W-1:0] TH3_UP   = CNT_W'(TH3);
  localparam logic [CNT_W-1:0] TH1_DN   = CNT_W'(TH1 - HYST);
  localparam logic [CNT_W-1:0] TH2_DN   = CNT_W'(TH2 - HYST);
  localparam logic [CNT_W-1:0] TH3_DN   = CNT_W'(TH3 - HYST);

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S10 = 2'b10,
    S11 = 2'b11
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             s1, s2, s3;
  logic             pulse_edge;
  logic             close_c;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] n_c;

  // Two-flop synchronizer plus an edge-detect flop; keeps running while A=0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pulse;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse_edge = s2 & ~s3;
  assign close_c    = (win_cnt == WIN_LAST);

  // Saturating count including an edge detected in the current cycle
  always_comb begin
    n_c = edge_cnt;
    if (pulse_edge && (edge_cnt != CNT_MAX)) n_c = edge_cnt + CNT_W'(1);
  end

  // Window / edge counters and the sampled count; A=0 clears and holds them
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_cnt      <= '0;
      edge_cnt     <= '0;
      rpm_count    <= '0;
      sample_valid <= 1'b0;
      band_change  <= 1'b0;
    end else begin
      band_change <= (state_next != state);
      if (!A) begin
        win_cnt      <= '0;
        edge_cnt     <= '0;
        rpm_count    <= '0;
        sample_valid <= 1'b0;
      end else begin
        sample_valid <= close_c;
        if (close_c) begin
          win_cnt   <= '0;
          edge_cnt  <= '0;
          rpm_count <= n_c;
        end else begin
          win_cnt  <= win_cnt + WIN_W'(1);
          edge_cnt <= n_c;
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S00;
    else        state <= state_next;
  end

  // Next state: evaluated only at window close, at most one band step
  always_comb begin
    state_next = state;
    if (!A) begin
      state_next = S00;
    end else if (close_c) begin
      case (state)
        S00: if (n_c >= TH1_UP) state_next = S01;
        S01: begin
          if (n_c >= TH2_UP)      state_next = S10;
          else if (n_c < TH1_DN)  state_next = S00;
        end
        S10: begin
          if (n_c >= TH3_UP)      state_next = S11;
          else if (n_c < TH2_DN)  state_next = S01;
        end
        S11: if (n_c < TH3_DN)  state_next = S10;
        default: state_next = S00;
      endcase
    end
  end

  // Moore output: band code is the state itself
  always_comb begin
    C = state;
  end

endmodule

// File: tb/tb_rpm_band_moore.sv
// Scoreboard bench for rpm_band_moore: stimulus pushes the expected sample
// per window, a monitor pops and compares whenever sample_valid is seen.
module tb_rpm_band_moore;

  localparam int unsigned W = 1000;

  typedef struct {
    int rpm;
    int c;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        A, pulse;
  logic [1:0]  C;
  logic [15:0] rpm_count;
  logic        sample_valid, band_change;

  logic        A2, pulse2;
  logic [1:0]  C2;
  logic [3:0]  rpm_count2;
  logic        sample_valid2, band_change2;

  int   checks = 0;
  int   errors = 0;
  int   bc_cnt = 0;
  int   bc0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  rpm_band_moore dut (
    .clk(clk), .reset(reset), .A(A), .pulse(pulse),
    .C(C), .rpm_count(rpm_count), .sample_valid(sample_valid), .band_change(band_change)
  );

  rpm_band_moore #(
    .WINDOW_CYCLES(100), .CNT_W(4), .TH1(5), .TH2(8), .TH3(12), .HYST(1)
  ) dut_sat (
    .clk(clk), .reset(reset), .A(A2), .pulse(pulse2),
    .C(C2), .rpm_count(rpm_count2), .sample_valid(sample_valid2), .band_change(band_change2)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // One full window starting at window cycle 0: n pulses (4 high / 4 low from
  // cycle 10), optionally one more rising at 997 so it is detected at close.
  task automatic run_window(input int n, input bit late, input int exp_c);
    exp_t e;
    e.rpm = n + (late ? 1 : 0);
    e.c   = exp_c;
    sb_q.push_back(e);
    for (int i = 0; i < int'(W); i++) begin
      if (late && i >= 997)                                 pulse = 1'b1;
      else if (i >= 10 && i < 10 + 8 * n && ((i - 10) % 8) < 4) pulse = 1'b1;
      else                                                  pulse = 1'b0;
      @(negedge clk);
    end
    chk("window_timing", 32'(sample_valid), 32'd1);
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (band_change === 1'b1) bc_cnt++;
      if (sample_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got sample rpm=%0d C=%0d expected no sample", rpm_count, C);
        end else begin
          e = sb_q.pop_front();
          chk("sb_rpm", 32'(rpm_count), 32'(e.rpm));
          chk("sb_c", 32'(C), 32'(e.c));
        end
      end
    end
  end

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  int sat_exp_c[4] = '{1, 2, 3, 3};

  initial begin
    reset = 1'b0; A = 1'b0; pulse = 1'b0; A2 = 1'b0; pulse2 = 1'b0;
    #1;
    chk("rst_c", 32'(C), 32'd0);
    chk("rst_rpm", 32'(rpm_count), 32'd0);
    chk("rst_sv", 32'(sample_valid), 32'd0);
    chk("rst_bc", 32'(band_change), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Climb: 50 edges per window, one band step per window
    bc0 = bc_cnt;
    A = 1'b1;
    run_window(50, 1'b0, 1);
    run_window(50, 1'b0, 2);
    run_window(50, 1'b0, 3);
    #1;
    chk("climb_bc", 32'(bc_cnt - bc0), 32'd3);
    chk("climb_c", 32'(C), 32'd3);

    // A drop from band 11
    A = 1'b0;
    @(negedge clk);
    #1;
    chk("drop_c", 32'(C), 32'd0);
    chk("drop_bc_strobe", 32'(band_change), 32'd1);
    repeat (50) @(negedge clk);
    #1;
    chk("drop_rpm", 32'(rpm_count), 32'd0);
    chk("drop_bc_cnt", 32'(bc_cnt - bc0), 32'd4);
    chk("drop_c_hold", 32'(C), 32'd0);

    // Hysteresis around the 10 band
    @(negedge clk);
    A = 1'b1;
    run_window(50, 1'b0, 1);
    run_window(50, 1'b0, 2);
    run_window(24, 1'b0, 2);
    run_window(22, 1'b0, 1);

    // Edge detected in the close cycle belongs to the closing window
    run_window(0, 1'b0, 0);
    run_window(9, 1'b1, 1);
    run_window(0, 1'b0, 0);

    // Asynchronous reset mid-window
    run_window(50, 1'b0, 1);
    run_window(50, 1'b0, 2);
    repeat (500) @(negedge clk);
    chk("pre_rst_c", 32'(C), 32'd2);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_c", 32'(C), 32'd0);
    chk("mid_rst_rpm", 32'(rpm_count), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_window(0, 1'b0, 0);

    // Saturation: CNT_W=4, 25 edges per 100-cycle window
    A = 1'b0;
    @(negedge clk);
    A2 = 1'b1;
    for (int i = 0; i <= 400; i++) begin
      if (i > 0 && (i % 100) == 0) begin
        chk("sat_sv", 32'(sample_valid2), 32'd1);
        chk("sat_rpm", 32'(rpm_count2), 32'd15);
        chk("sat_c", 32'(C2), 32'(sat_exp_c[i / 100 - 1]));
      end
      pulse2 = ((i % 4) < 2);
      if (i < 400) @(negedge clk);
    end
    A2 = 1'b0;

    // Drain scoreboard with a bound
    for (int k = 0; k < 2000 && sb_q.size() != 0; k++) @(negedge clk);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
